// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter
//   Shares one 2:1 mux datapath between two requesters. A round-robin arbiter
//   with a bounded hold time drives the mux select. The selected data is
//   returned on a registered output together with a valid strobe.
//
// Optional feature macro: MUX_ARB_LOCK_EN
//   Defined     - adds the lock input. While the owner keeps its request up
//                 and lock is high, the forced handover is suppressed.
//   Not defined - no lock port. The forced handover after MAX_HOLD cycles
//                 always applies.
//
// Parameters
//   W         data width of x0, x1 and f
//   MAX_HOLD  max consecutive grant cycles before forced handover (>= 1)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [1:0] level-sensitive requests
//   x0, x1  in   [W-1:0] requester data
//   lock    in   owner hold-off (MUX_ARB_LOCK_EN only)
//   gnt     out  [1:0] registered grant, one-hot or zero
//   s       out  mux select (gnt[1])
//   f       out  [W-1:0] registered mux output
//   valid   out  registered; f carries owner data this cycle
module mux_share_arbiter #(
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
`ifdef MUX_ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic [1:0]   gnt,
    output logic         s,
    output logic [W-1:0] f,
    output logic         valid
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_e         state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic           rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   f_q, f_d;
    logic           valid_q, valid_d;

    logic           lock_act;
    logic           own;      // index of the current owner (valid in OWN states)
    logic           oth;      // index of the other requester
    logic           mine_req;
    logic           oth_req;
    logic           leave;

`ifdef MUX_ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    // Grant is a pure decode of the state register, so it is registered.
    assign gnt   = {state_q == StOwn1, state_q == StOwn0};
    assign s     = gnt[1];
    assign f     = f_q;
    assign valid = valid_q;

    assign own      = (state_q == StOwn1);
    assign oth      = ~own;
    assign mine_req = req[own];
    assign oth_req  = req[oth];

    // Leave when the owner drops, or when the hold budget is spent while the
    // other side waits (unless the owner holds lock).
    assign leave = !mine_req || (oth_req && (hold_cnt_q == HoldLast) && !lock_act);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                hold_cnt_d = '0;
                if (req == 2'b11) begin
                    state_d = rr_ptr_q ? StOwn1 : StOwn0;
                end else if (req[0]) begin
                    state_d = StOwn0;
                end else if (req[1]) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (leave) begin
                    // Direct handover when the other side is waiting; no dead cycle.
                    if (oth_req) begin
                        state_d = own ? StOwn0 : StOwn1;
                    end else begin
                        state_d = StIdle;
                    end
                    rr_ptr_d   = oth;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HoldLast) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Datapath: one cycle behind the grant, f holds when nothing is transferred.
    always_comb begin
        valid_d = |(gnt & req);
        f_d     = f_q;
        if (valid_d) begin
            f_d = gnt[1] ? x1 : x0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
            f_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            f_q        <= f_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
module tb_mux_share_arbiter;

    localparam int unsigned W        = 8;
    localparam int unsigned MAX_HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic         lock;
    logic [1:0]   gnt;
    logic         s;
    logic [W-1:0] f;
    logic         valid;

    int checks   = 0;
    int failures = 0;

    mux_share_arbiter #(
        .W        (W),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .x0    (x0),
        .x1    (x1),
`ifdef MUX_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .s     (s),
        .f     (f),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 idle), length of the current grant run,
    // and which requester wins the next tie.
    int           m_owner;
    int           m_run;
    int           m_tie;
    logic [W-1:0] m_f;
    logic         m_valid;

    function automatic void model_reset();
        m_owner = -1;
        m_run   = 0;
        m_tie   = 0;
        m_f     = '0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_step();
        int prev;
        int nxt;
        int other;
        prev    = m_owner;
        m_valid = (prev >= 0) && req[prev];
        if (m_valid) m_f = (prev == 1) ? x1 : x0;
        if (prev < 0) begin
            if (req == 2'b11)  nxt = m_tie;
            else if (req[0])   nxt = 0;
            else if (req[1])   nxt = 1;
            else               nxt = -1;
        end else begin
            other = 1 - prev;
            if (!req[prev])                                    nxt = req[other] ? other : -1;
            else if (req[other] && m_run >= MAX_HOLD && !lock) nxt = other;
            else                                               nxt = prev;
        end
        if (prev >= 0 && nxt != prev) m_tie = 1 - prev;
        m_run   = (nxt != prev) ? 1 : m_run + 1;
        m_owner = nxt;
    endfunction

    function automatic logic [1:0] model_gnt();
        if (m_owner < 0) return 2'b00;
        return (m_owner == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are already set; advance one edge, update the model, sample after.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b00;
        lock  = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0] req;
        logic [7:0] x0;
        logic [7:0] x1;
        logic [1:0] gnt;
        logic       valid;
        logic [7:0] f;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int owner_prev;
        int owner_now;
        rst_n = 1'b0;
        req   = 2'b00;
        x0    = '0;
        x1    = '0;
        lock  = 1'b0;
        #12;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_f", 32'(f), 32'h0);
        chk("reset_s", 32'(s), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors from reset: single owner, drop, tie with rr_ptr=1,
        // drop-with-handover in both directions.
        tbl[0]  = '{2'b01, 8'hA5, 8'h5A, 2'b01, 1'b0, 8'h00};
        tbl[1]  = '{2'b01, 8'hA5, 8'h5A, 2'b01, 1'b1, 8'hA5};
        tbl[2]  = '{2'b00, 8'h11, 8'h22, 2'b00, 1'b0, 8'hA5};
        tbl[3]  = '{2'b00, 8'h33, 8'h44, 2'b00, 1'b0, 8'hA5};
        tbl[4]  = '{2'b11, 8'h01, 8'h02, 2'b10, 1'b0, 8'hA5};
        tbl[5]  = '{2'b11, 8'h03, 8'h04, 2'b10, 1'b1, 8'h04};
        tbl[6]  = '{2'b10, 8'h05, 8'h06, 2'b10, 1'b1, 8'h06};
        tbl[7]  = '{2'b01, 8'h07, 8'h08, 2'b01, 1'b0, 8'h06};
        tbl[8]  = '{2'b01, 8'h09, 8'h0F, 2'b01, 1'b1, 8'h09};
        tbl[9]  = '{2'b10, 8'h1F, 8'h0A, 2'b10, 1'b0, 8'h09};
        tbl[10] = '{2'b11, 8'h0B, 8'h0C, 2'b10, 1'b1, 8'h0C};
        for (int i = 0; i < 11; i++) begin
            req = tbl[i].req;
            x0  = tbl[i].x0;
            x1  = tbl[i].x1;
            cyc();
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d_s", i), 32'(s), 32'(tbl[i].gnt[1]));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d_f", i), 32'(f), 32'(tbl[i].f));
        end

        // Reset asserted mid-cycle while granted: outputs clear without an edge.
        req = 2'b01;
        x0  = 8'hC3;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_s", 32'(s), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_f", 32'(f), 32'h0);
        do_reset();

        // Tie after reset and fairness: blocks of MAX_HOLD grants alternating.
        req = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            x0 = 8'(8'h30 + k);
            x1 = 8'(8'h80 + k);
            cyc();
            owner_now  = ((k - 1) / MAX_HOLD) % 2;
            owner_prev = ((k - 2) / MAX_HOLD) % 2;
            chk($sformatf("fair%0d_gnt", k), 32'(gnt), (owner_now == 0) ? 32'h1 : 32'h2);
            chk($sformatf("fair%0d_valid", k), 32'(valid), (k > 1) ? 32'h1 : 32'h0);
            if (k > 1)
                chk($sformatf("fair%0d_f", k), 32'(f),
                    (owner_prev == 1) ? 32'(8'h80 + k) : 32'(8'h30 + k));
        end
        do_reset();

        // No idle preemption; after the long run the saturated hold count
        // makes the handover immediate once requester 1 arrives.
        req = 2'b01;
        x0  = 8'h5C;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("nopre%0d_gnt", k), 32'(gnt), 32'h1);
        end
        chk("nopre_f", 32'(f), 32'h5C);
        req = 2'b11;
        cyc();
        chk("sat_handover_gnt", 32'(gnt), 32'h2);
        do_reset();

`ifdef MUX_ARB_LOCK_EN
        // Lock keeps the grant past MAX_HOLD; dropping it hands over next edge.
        req = 2'b11;
        cyc();
        chk("lock_entry_gnt", 32'(gnt), 32'h1);
        lock = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("lock%0d_gnt", k), 32'(gnt), 32'h1);
        end
        lock = 1'b0;
        cyc();
        chk("unlock_gnt", 32'(gnt), 32'h2);
        do_reset();
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            x0 = 8'($urandom);
            x1 = 8'($urandom);
`ifdef MUX_ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
            cyc();
            chk("rnd_gnt", 32'(gnt), 32'(model_gnt()));
            chk("rnd_s", 32'(s), 32'(model_gnt() >> 1));
            chk("rnd_valid", 32'(valid), 32'(m_valid));
            chk("rnd_f", 32'(f), 32'(m_f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
